// File: rtl/mic1_mem_arbiter.sv
// Arbitrates MIC-1 word (read/write) and byte-fetch requests onto a narrow
// 8-bit multiplexed bus: two address beats, then 1 (fetch) or 4 (word) data beats.
module mic1_mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        word_rd,
    input  logic        word_wr,
    input  logic [13:0] mar,
    input  logic [31:0] mdr_wdata,
    input  logic        fetch_req,
    input  logic [15:0] pc,
    output logic [31:0] mdr_rdata,
    output logic        word_done,
    output logic [7:0]  mbr,
    output logic        fetch_done,
    output logic        busy,
    output logic        err,
    output logic [1:0]  bus_cmd,
    output logic [7:0]  bus_out,
    output logic        bus_oe,
    input  logic [7:0]  bus_in,
    input  logic        bus_ack
);
    typedef enum logic [1:0] {IDLE, AHI, ALO, DATA} state_t;

    state_t      state, state_nx;
    logic        pend_w, pend_wr, pend_f, rr_f;
    logic        cur_word, cur_wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [1:0]  beat;
    logic        want_w, want_wr, want_f, grant_w, grant_f, last_beat, word_active;
    logic [7:0]  wr_byte;

    // A pending request or a fresh pulse this cycle both compete in IDLE.
    assign want_w      = pend_w | word_rd | word_wr;
    assign want_wr     = pend_w ? pend_wr : word_wr;
    assign want_f      = pend_f | fetch_req;
    assign grant_w     = (state == IDLE) & want_w & ~(want_f & rr_f);
    assign grant_f     = (state == IDLE) & want_f & ~grant_w;
    assign last_beat   = cur_word ? (beat == 2'd3) : 1'b1;
    assign word_active = (state != IDLE) & cur_word;
    assign busy        = pend_w | pend_f | (state != IDLE);

    always_comb begin
        case (beat)
            2'd0:    wr_byte = wdata[31:24];
            2'd1:    wr_byte = wdata[23:16];
            2'd2:    wr_byte = wdata[15:8];
            default: wr_byte = wdata[7:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        bus_cmd  = 2'b00;
        bus_out  = 8'h00;
        bus_oe   = 1'b0;
        case (state)
            IDLE: if (grant_w | grant_f) state_nx = AHI;
            AHI: begin
                bus_cmd = 2'b01;
                bus_out = addr[15:8];
                bus_oe  = 1'b1;
                if (bus_ack) state_nx = ALO;
            end
            ALO: begin
                bus_cmd = 2'b01;
                bus_out = addr[7:0];
                bus_oe  = 1'b1;
                if (bus_ack) state_nx = DATA;
            end
            default: begin
                bus_cmd = cur_wr ? 2'b11 : 2'b10;
                bus_out = cur_wr ? wr_byte : 8'h00;
                bus_oe  = cur_wr;
                if (bus_ack && last_beat) state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_w     <= 1'b0;
            pend_wr    <= 1'b0;
            pend_f     <= 1'b0;
            rr_f       <= 1'b0;
            cur_word   <= 1'b0;
            cur_wr     <= 1'b0;
            addr       <= 16'h0;
            wdata      <= 32'h0;
            beat       <= 2'd0;
            mdr_rdata  <= 32'h0;
            mbr        <= 8'h0;
            word_done  <= 1'b0;
            fetch_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            err        <= word_rd & word_wr;
            word_done  <= (state == DATA) & bus_ack & last_beat & cur_word;
            fetch_done <= (state == DATA) & bus_ack & last_beat & ~cur_word;

            // Repeats while the same requester is pending or in service are dropped.
            if (grant_w) pend_w <= 1'b0;
            else if ((word_rd | word_wr) & ~pend_w & ~word_active) begin
                pend_w  <= 1'b1;
                pend_wr <= word_wr;
            end
            if (grant_f) pend_f <= 1'b0;
            else if (fetch_req & ~pend_f & ~((state != IDLE) & ~cur_word)) pend_f <= 1'b1;

            if (grant_w | grant_f) begin
                addr     <= grant_w ? {mar, 2'b00} : pc;
                cur_word <= grant_w;
                cur_wr   <= grant_w & want_wr;
                rr_f     <= grant_w;
                beat     <= 2'd0;
                if (grant_w) wdata <= mdr_wdata;
            end

            if (state == DATA && bus_ack) begin
                beat <= beat + 2'd1;
                if (!cur_wr) begin
                    if (!cur_word) mbr <= bus_in;
                    else case (beat)
                        2'd0:    mdr_rdata[31:24] <= bus_in;
                        2'd1:    mdr_rdata[23:16] <= bus_in;
                        2'd2:    mdr_rdata[15:8]  <= bus_in;
                        default: mdr_rdata[7:0]   <= bus_in;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_mic1_mem_arbiter.sv
// Bench for mic1_mem_arbiter: directed scenarios plus randomized transfers
// checked beat-by-beat against a transaction-level expectation list.
module tb_mic1_mem_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic        word_rd = 0, word_wr = 0, fetch_req = 0, bus_ack = 0;
    logic [13:0] mar = 0;
    logic [31:0] mdr_wdata = 0;
    logic [15:0] pc = 0;
    logic [7:0]  bus_in = 0;
    logic [31:0] mdr_rdata;
    logic [7:0]  mbr, bus_out;
    logic        word_done, fetch_done, busy, err, bus_oe;
    logic [1:0]  bus_cmd;

    int checks = 0, failures = 0;
    logic [31:0] mdr_m = 0;
    logic [7:0]  mbr_m = 0;
    bit          last_was_word = 0;

    mic1_mem_arbiter dut (
        .clk(clk), .rst(rst), .word_rd(word_rd), .word_wr(word_wr), .mar(mar),
        .mdr_wdata(mdr_wdata), .fetch_req(fetch_req), .pc(pc), .mdr_rdata(mdr_rdata),
        .word_done(word_done), .mbr(mbr), .fetch_done(fetch_done), .busy(busy),
        .err(err), .bus_cmd(bus_cmd), .bus_out(bus_out), .bus_oe(bus_oe),
        .bus_in(bus_in), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // kind: 0 word read, 1 word write, 2 fetch. Call at a negedge.
    task automatic issue(input int kind, input logic [15:0] a, input logic [31:0] wd, input bit both);
        case (kind)
            0:       word_rd = 1;
            1:       begin word_wr = 1; word_rd = both; end
            default: fetch_req = 1;
        endcase
        if (kind == 2) pc = a;
        else begin mar = a[15:2]; mdr_wdata = wd; end
    endtask

    // Walks one granted transfer: expected bus beats are listed up front and the
    // list index only advances on an acked beat, so stalls must hold outputs.
    task automatic serve(input int kind, input logic [15:0] a, input logic [31:0] wd,
                         input bit chk_err, input bit exp_err, input int dens,
                         input bit fixed, input logic [31:0] bseq, input bit other_pend);
        logic [1:0]  ec [6];
        logic [7:0]  eo [6];
        logic        eoe[6];
        logic [31:0] rd = 0;
        int n = (kind == 2) ? 3 : 6;
        int idx = 0, cyc = 0;
        ec[0] = 2'b01; eo[0] = a[15:8]; eoe[0] = 1;
        ec[1] = 2'b01; eo[1] = a[7:0];  eoe[1] = 1;
        for (int b = 0; b < 4; b++) begin
            ec[2+b]  = (kind == 1) ? 2'b11 : 2'b10;
            eo[2+b]  = wd[31-8*b -: 8];
            eoe[2+b] = (kind == 1);
        end
        while (idx < n && cyc < 200) begin
            @(negedge clk);
            word_rd = 0; word_wr = 0; fetch_req = 0;
            if (cyc == 0 && chk_err) chk("err_pulse", {31'b0, err}, {31'b0, exp_err});
            chk("bus_cmd", {30'b0, bus_cmd}, {30'b0, ec[idx]});
            chk("bus_oe", {31'b0, bus_oe}, {31'b0, eoe[idx]});
            if (eoe[idx]) chk("bus_out", {24'b0, bus_out}, {24'b0, eo[idx]});
            chk("busy_xfer", {31'b0, busy}, 32'd1);
            chk("done_early", {30'b0, word_done, fetch_done}, 32'd0);
            bus_ack = (dens >= 100) || ($urandom_range(99) < dens);
            bus_in  = (fixed && idx >= 2) ? bseq[31-8*(idx-2) -: 8] : 8'($urandom);
            if (bus_ack) begin
                if (idx >= 2) rd[31-8*(idx-2) -: 8] = bus_in;
                idx++;
            end
            cyc++;
        end
        if (idx < n) chk("xfer_timeout", idx, n);
        @(negedge clk);
        bus_ack = 0;
        if (kind == 0) mdr_m = rd;
        if (kind == 2) mbr_m = rd[31:24];
        chk("done_pulse", {30'b0, word_done, fetch_done}, (kind == 2) ? 32'd1 : 32'd2);
        chk("mdr_rdata", mdr_rdata, mdr_m);
        chk("mbr", {24'b0, mbr}, {24'b0, mbr_m});
        chk("busy_done", {31'b0, busy}, {31'b0, other_pend});
        chk("idle_cmd", {21'b0, bus_cmd, bus_oe, bus_out}, 32'd0);
        last_was_word = (kind != 2);
    endtask

    task automatic pair(input logic [15:0] wa, input logic [31:0] wd, input logic [15:0] fa);
        bit word_first = !last_was_word;
        issue(1, wa, wd, 0);
        issue(2, fa, 0, 0);
        if (word_first) begin
            serve(1, wa, wd, 1, 0, 100, 0, 0, 1);
            serve(2, fa, 0, 0, 0, 100, 0, 0, 0);
        end else begin
            serve(2, fa, 0, 1, 0, 100, 0, 0, 1);
            serve(1, wa, wd, 0, 0, 100, 0, 0, 0);
        end
    endtask

    initial begin
        #1;
        chk("rst_outputs", {mdr_rdata}, 32'd0);
        chk("rst_misc", {20'b0, mbr, word_done, fetch_done, busy, err}, 32'd0);
        chk("rst_bus", {21'b0, bus_cmd, bus_oe, bus_out}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 0;

        // Back-to-back read, ack tied high, fixed bytes.
        issue(0, 16'h0040, 0, 0);
        serve(0, 16'h0040, 0, 1, 0, 100, 1, 32'h12345678, 0);
        chk("read_word", mdr_rdata, 32'h12345678);

        // Fetch issued in the done cycle: no dead cycle allowed.
        issue(2, 16'hA5C3, 0, 0);
        serve(2, 16'hA5C3, 0, 1, 0, 100, 1, 32'h5A000000, 0);

        // Read+write together: write wins, err pulses, mdr_rdata untouched.
        issue(1, 16'h1234, 32'hDEADBEEF, 1);
        serve(1, 16'h1234, 32'hDEADBEEF, 1, 1, 100, 0, 0, 0);

        // Contention twice: order alternates.
        pair(16'h0100, 32'hCAFEF00D, 16'h0203);
        pair(16'h0300, 32'h01020304, 16'h0405);

        // Stalling ack.
        issue(0, 16'h7FFC, 0, 0);
        serve(0, 16'h7FFC, 0, 1, 0, 40, 0, 0, 0);

        // Reset during DATA beat 2.
        issue(0, 16'h0010, 0, 0);
        repeat (4) begin
            @(negedge clk);
            word_rd = 0; bus_ack = 1; bus_in = 8'($urandom);
        end
        @(negedge clk);
        chk("pre_rst_cmd", {30'b0, bus_cmd}, 32'd2);
        rst = 1; word_rd = 1; fetch_req = 1; bus_ack = 0;
        #1;
        chk("rst_async_bus", {21'b0, bus_cmd, bus_oe, bus_out}, 32'd0);
        chk("rst_async_data", {mdr_rdata[31:8] | {16'b0, mbr}, 6'b0, busy, word_done}, 32'd0);
        @(negedge clk);
        rst = 0; word_rd = 0; fetch_req = 0;
        mdr_m = 0; mbr_m = 0; last_was_word = 0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_quiet", {29'b0, busy, word_done, fetch_done}, 32'd0);
        end
        chk("post_rst_mdr", mdr_rdata, 32'd0);
        pair(16'h0AB0, 32'h89ABCDEF, 16'h0C0D);

        // Randomized transfers.
        for (int t = 0; t < 30; t++) begin
            int k = $urandom_range(2);
            bit both = (k == 1) && ($urandom_range(1) == 1);
            logic [15:0] a = 16'($urandom);
            logic [31:0] wd = $urandom;
            if (k != 2) a[1:0] = 2'b00;
            issue(k, a, wd, both);
            serve(k, a, wd, 1, both, $urandom_range(100, 30), 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mic1_mem_arbiter.md
MIC1_MEM_ARBITER -- requirements
Module: mic1_mem_arbiter

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port word_rd  input  1  one-cycle pulse from the microsequencer requesting a 32-bit read at mar.
REQ-004 SHALL have port word_wr  input  1  one-cycle pulse requesting a 32-bit write of mdr_wdata to mar.
REQ-005 SHALL have port mar  input  14  word address; byte address = {mar,2'b00}.
REQ-006 SHALL have port mdr_wdata  input  32  write data, sampled at grant.
REQ-007 SHALL have port fetch_req  input  1  one-cycle pulse requesting a byte fetch at pc.
REQ-008 SHALL have port pc  input  16  byte address for fetch, sampled at grant.
REQ-009 SHALL have port mdr_rdata  output  32  read word (MSB byte first on bus).
REQ-010 SHALL have port word_done  output  1  one-cycle pulse: word read or write complete.
REQ-011 SHALL have port mbr  output  8  fetched byte.
REQ-012 SHALL have port fetch_done  output  1  one-cycle pulse: fetch complete.
REQ-013 SHALL have port busy  output  1  high when any request is pending or in progress.
REQ-014 SHALL have port err  output  1  one-cycle pulse when word_rd and word_wr are sampled high together.
REQ-015 SHALL have port bus_cmd  output  2  00 IDLE, 01 ADDR, 10 READ, 11 WRITE.
REQ-016 SHALL have port bus_out  output  8  address or write byte.
REQ-017 SHALL have port bus_oe  output  1  drive enable for bus_out.
REQ-018 SHALL have port bus_in  input  8  read byte from external memory.
REQ-019 SHALL have port bus_ack  input  1  beat accepted; external memory auto-increments its address after each data beat.

Function
REQ-020 SHALL latch word and fetch requests into separate pending bits; a repeat request while the same pending bit is set or in service is ignored.
REQ-021 SHALL give simultaneous word_rd&word_wr a write, and pulse err in the following cycle.
REQ-022 SHALL implement the states IDLE, AHI, ALO and DATA.
REQ-023 In IDLE with a pending request or a new request this cycle, SHALL grant at the clock edge and enter AHI.
REQ-024 When both requesters contend, SHALL grant round-robin: the one not granted last; after reset, word goes first.
REQ-025 SHALL capture address, direction and write data in the grant edge.
REQ-026 AHI: bus_cmd=01, bus_out=addr[15:8], bus_oe=1; SHALL advance to ALO on the edge where bus_ack=1.
REQ-027 ALO: bus_cmd=01, bus_out=addr[7:0], bus_oe=1; SHALL advance to DATA on bus_ack.
REQ-028 DATA uses a 2-bit beat counter; word transfers use 4 beats (beat 0 = bits 31:24), fetch uses 1 beat.
REQ-029 DATA read: bus_cmd=10, bus_oe=0; on bus_ack SHALL load bus_in into the addressed byte of mdr_rdata, or into mbr for fetch.
REQ-030 DATA write: bus_cmd=11, bus_oe=1, bus_out=current byte.
REQ-031 Every state SHALL hold indefinitely while bus_ack=0; bus_ack in IDLE is ignored.
REQ-032 On the last-beat ack SHALL return to IDLE and pulse word_done or fetch_done in the next cycle (the first IDLE cycle), with data already valid.
REQ-033 SHALL be able to grant a new request in that same IDLE cycle (no dead cycle).
REQ-034 SHALL hold mdr_rdata and mbr between transfers; a write SHALL NOT alter mdr_rdata.
REQ-035 In IDLE SHALL drive bus_cmd=00, bus_oe=0, bus_out=0.

Reset
REQ-036 rst SHALL immediately force IDLE, clear pending bits, clear the round-robin pointer, and zero mdr_rdata, mbr, all pulses, busy, bus_cmd, bus_out and bus_oe.
REQ-037 Reset mid-transfer SHALL abort the transfer without emitting any done pulse; requests presented during reset are dropped.

Verification
REQ-038 bus_ack tied high, word_rd pulse at cycle 0, bus_in sequence 12,34,56,78 -> cmd 01,01,10,10,10,10 in cycles 1-6; word_done and mdr_rdata=0x12345678 in cycle 7.
REQ-039 bus_ack tied high, fetch_req with pc=0xA5C3 -> bus_out C3 is preceded by A5; fetch_done in cycle 4 with mbr=bus_in.
REQ-040 word_wr and fetch_req in the same cycle, then both again after completion -> order word, fetch, then fetch, word (round-robin); busy stays high throughout.
REQ-041 bus_ack low for 3 cycles in ALO -> state and outputs held; total word latency extends by 3 cycles.
REQ-042 word_rd and word_wr together with mdr_wdata=0xDEADBEEF -> err pulse; WRITE beats DE,AD,BE,EF; mdr_rdata unchanged.
REQ-043 rst asserted during DATA beat 2 -> outputs zero asynchronously; no word_done; a fresh request after reset completes normally.
